mux_sel_arbiter: RTL

//  Upstream stage of the 8-bit 2:1 mux datapath. Arbitrates two valid/ready byte sources (A, B) round-robin.

---
 rtl/mux_sel_arb_pkg.sv | 34 +++
 rtl/rr2_arbiter.sv | 31 +++
 rtl/mux_sel_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_sel_arb_pkg.sv
// Shared types for the mux select arbiter: source identifiers, FSM states and default widths.
// Optional grant statistics are enabled with the MUX_SEL_ARB_STATS_EN macro.
package mux_sel_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {
        SRC_B = 1'b0,
        SRC_A = 1'b1
    } src_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

    // Round-robin tie-break: when both sources request, the one not served last wins.
    function automatic src_e rr_pick(input logic req_a, input logic req_b, input src_e last);
        src_e pick;
        pick = SRC_B;
        if (req_a && req_b) begin
            if (last == SRC_A) begin
                pick = SRC_B;
            end else begin
                pick = SRC_A;
            end
        end else if (req_a) begin
            pick = SRC_A;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr2_arbiter.sv
// Two-request round-robin arbiter. Owns the last-grant history, which advances only on an
// enabled, valid grant so that stalled cycles do not disturb fairness.
module rr2_arbiter
    import mux_sel_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic en,
    output src_e gnt,
    output logic gnt_vld
);

    src_e last_grant;

    always_comb begin
        gnt     = rr_pick(req_a, req_b, last_grant);
        gnt_vld = en && (req_a || req_b);
    end

    // Last grant starts as B so the first contention after reset goes to A.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SRC_B;
        end else if (en && gnt_vld) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin front end for the 8-bit 2:1 mux: one-entry output register, mux select and
// per-source data copies. Grant counters exist only when MUX_SEL_ARB_STATS_EN is defined.
module mux_sel_arbiter
    import mux_sel_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              sel_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    input  logic              y_ready_i,
    output logic [CNT_W-1:0]  a_grants_o,
    output logic [CNT_W-1:0]  b_grants_o
);

    state_e state;
    src_e   gnt;
    logic   gnt_vld;
    logic   can_load;

    // A full register may be refilled in the same cycle it drains, giving one byte per cycle.
    assign can_load  = (state == ST_EMPTY) || y_ready_i;
    assign y_valid_o = (state == ST_FULL);
    assign a_ready_o = gnt_vld && (gnt == SRC_A);
    assign b_ready_o = gnt_vld && (gnt == SRC_B);

    rr2_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_a   (a_valid_i),
        .req_b   (b_valid_i),
        .en      (can_load && !reset),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    // sel_o and the a_o/b_o copies move together with y_data_o, so the downstream mux
    // always reproduces the byte held in the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            y_data_o <= '0;
            a_o      <= '0;
            b_o      <= '0;
            sel_o    <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (gnt_vld) begin
                        state    <= ST_FULL;
                        sel_o    <= (gnt == SRC_A);
                        if (gnt == SRC_A) begin
                            y_data_o <= a_data_i;
                            a_o      <= a_data_i;
                        end else begin
                            y_data_o <= b_data_i;
                            b_o      <= b_data_i;
                        end
                    end
                end
                ST_FULL: begin
                    if (gnt_vld) begin
                        sel_o    <= (gnt == SRC_A);
                        if (gnt == SRC_A) begin
                            y_data_o <= a_data_i;
                            a_o      <= a_data_i;
                        end else begin
                            y_data_o <= b_data_i;
                            b_o      <= b_data_i;
                        end
                    end else if (y_ready_i) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

`ifdef MUX_SEL_ARB_STATS_EN
    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] b_cnt;

    // Handshake counters wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (a_ready_o) begin
                a_cnt <= a_cnt + CNT_W'(1);
            end
            if (b_ready_o) begin
                b_cnt <= b_cnt + CNT_W'(1);
            end
        end
    end

    assign a_grants_o = a_cnt;
    assign b_grants_o = b_cnt;
`else
    assign a_grants_o = '0;
    assign b_grants_o = '0;
`endif

endmodule
